servo_uart_cmd: RTL and testbench



---
 rtl/servo_uart_cmd.sv | 199 +++++++++++++++++++
 tb/tb_servo_uart_cmd.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_uart_cmd.sv
// servo_uart_cmd: 8N1 UART receiver plus 3-byte angle frame parser.
// Converts a validated angle into a PWM pulse width in clock cycles.
module servo_uart_cmd #(
  parameter int unsigned CLK_FREQ       = 25_000_000,
  parameter int unsigned BAUD           = 115_200,
  parameter int unsigned PERIOD         = 500_000,
  parameter int unsigned MIN_PULSE      = 25_000,
  parameter int unsigned MAX_PULSE      = 50_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] duty_cycle,
  output logic [31:0] period,
  output logic        cmd_valid,
  output logic        cmd_err,
  output logic        rx_busy
);

  localparam int unsigned CPB      = CLK_FREQ / BAUD;
  localparam logic [31:0] CPB_M1   = 32'(CPB - 1);
  localparam logic [31:0] HALF_M1  = 32'(CPB / 2 - 1);
  localparam logic [31:0] TO_M1    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] STEP     = 32'((MAX_PULSE - MIN_PULSE) / 180);
  localparam logic [31:0] MIN_P    = 32'(MIN_PULSE);
  localparam logic [31:0] RST_DUTY = MIN_P + 32'd90 * STEP;

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    P_HUNT, P_HDR, P_ANG
  } p_state_e;

  logic        rx_s1_q;
  logic        rx_s2_q;
  logic        rx_prev_q;
  rx_state_e   rstate_q;
  logic [31:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shreg_q;
  logic        rx_busy_q;
  logic        byte_done_q;
  logic        frame_err_q;
  p_state_e    pstate_q;
  logic [7:0]  angle_q;
  logic [31:0] gap_q;
  logic [31:0] duty_q;
  logic [31:0] duty_d;
  logic        valid_q;
  logic        err_q;
  logic        fall;

  assign fall       = rx_prev_q & ~rx_s2_q;
  assign duty_cycle = duty_q;
  assign period     = 32'(PERIOD);
  assign cmd_valid  = valid_q;
  assign cmd_err    = err_q;
  assign rx_busy    = rx_busy_q;

  // Candidate pulse width for the latched angle.
  always_comb begin
    duty_d = MIN_P + {24'd0, angle_q} * STEP;
  end

  // Two-flop synchroniser plus previous value for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Byte receiver; a low stop bit re-arms only after rx rises again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q    <= R_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      rx_busy_q   <= 1'b0;
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (rstate_q)
        R_IDLE: begin
          if (fall) begin
            rstate_q  <= R_START;
            cnt_q     <= '0;
            rx_busy_q <= 1'b1;
          end
        end
        R_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (!rx_s2_q) begin
              rstate_q  <= R_DATA;
              bit_idx_q <= '0;
            end else begin
              rstate_q  <= R_IDLE;
              rx_busy_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        R_DATA: begin
          if (cnt_q == CPB_M1) begin
            cnt_q   <= '0;
            shreg_q <= {rx_s2_q, shreg_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              rstate_q <= R_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        R_STOP: begin
          if (cnt_q == CPB_M1) begin
            cnt_q     <= '0;
            rstate_q  <= R_IDLE;
            rx_busy_q <= 1'b0;
            if (rx_s2_q) begin
              byte_done_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  // Frame parser with inter-byte timeout; owns duty and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate_q <= P_HUNT;
      angle_q  <= '0;
      gap_q    <= '0;
      duty_q   <= RST_DUTY;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (frame_err_q) begin
        err_q    <= 1'b1;
        pstate_q <= P_HUNT;
        gap_q    <= '0;
      end else if (byte_done_q) begin
        gap_q <= '0;
        unique case (pstate_q)
          P_HUNT: begin
            if (shreg_q == 8'hA5) begin
              pstate_q <= P_HDR;
            end
          end
          P_HDR: begin
            angle_q  <= shreg_q;
            pstate_q <= P_ANG;
          end
          P_ANG: begin
            pstate_q <= P_HUNT;
            if (shreg_q == ~angle_q && angle_q <= 8'd180) begin
              duty_q  <= duty_d;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          default: pstate_q <= P_HUNT;
        endcase
      end else if (pstate_q != P_HUNT) begin
        if (gap_q == TO_M1) begin
          err_q    <= 1'b1;
          pstate_q <= P_HUNT;
          gap_q    <= '0;
        end else begin
          gap_q <= gap_q + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_servo_uart_cmd.sv
// tb_servo_uart_cmd: directed UART frames against a byte-level model.
// Uses a short bit time and timeout to keep the run compact.
module tb_servo_uart_cmd;

  localparam int CPB    = 16;
  localparam int HALF   = 8;
  localparam int TMO    = 2000;
  localparam int STEP_B = (50_000 - 25_000) / 180;
  localparam int RST_D  = 25_000 + 90 * STEP_B;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [31:0] duty_cycle;
  logic [31:0] period;
  logic        cmd_valid;
  logic        cmd_err;
  logic        rx_busy;

  servo_uart_cmd #(
    .CLK_FREQ      (1_600_000),
    .BAUD          (100_000),
    .PERIOD        (500_000),
    .MIN_PULSE     (25_000),
    .MAX_PULSE     (50_000),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .duty_cycle(duty_cycle),
    .period    (period),
    .cmd_valid (cmd_valid),
    .cmd_err   (cmd_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef enum {M_HUNT, M_HDR, M_ANG} mst_e;
  mst_e        m_st;
  int          m_ang;
  int          m_valid = 0;
  int          m_err = 0;
  int          m_upd_cyc = 0;
  int          m_deadline = 0;
  logic [31:0] m_duty;
  logic [31:0] m_old;

  int          dut_valid = 0;
  int          dut_err = 0;
  int          last_valid_cyc = 0;
  int          last_err_cyc = 0;
  logic [31:0] prev_duty;
  logic        pv = 1'b0;
  logic        pe = 1'b0;

  function automatic void m_reset();
    m_st       = M_HUNT;
    m_duty     = 32'(RST_D);
    m_old      = 32'(RST_D);
    m_deadline = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input logic ok);
    m_upd_cyc  = cyc;
    m_old      = m_duty;
    m_deadline = cyc + 10;
    if (!ok) begin
      m_err++;
      m_st = M_HUNT;
    end else if (m_st == M_HUNT) begin
      if (b == 8'hA5) m_st = M_HDR;
    end else if (m_st == M_HDR) begin
      m_ang = int'(b);
      m_st  = M_ANG;
    end else begin
      if ((m_ang ^ 255) == int'(b) && m_ang <= 180) begin
        m_valid++;
        m_duty = 32'(25_000 + m_ang * STEP_B);
      end else begin
        m_err++;
      end
      m_st = M_HUNT;
    end
  endfunction

  // Per-cycle tracking of outputs against the model.
  always @(negedge clk) begin
    if (rst) begin
      prev_duty = duty_cycle;
      pv = 1'b0;
      pe = 1'b0;
    end else begin
      if (cmd_valid) begin
        dut_valid++;
        last_valid_cyc = cyc;
      end
      if (cmd_err) begin
        dut_err++;
        last_err_cyc = cyc;
      end
      n_cmp++;
      if (cmd_valid && cmd_err) begin
        n_fail++;
        $display("FAIL both_pulses cyc=%0d valid=%b err=%b req both not 1",
                 cyc, cmd_valid, cmd_err);
      end
      n_cmp++;
      if (period !== 32'd500_000) begin
        n_fail++;
        $display("FAIL period cyc=%0d got %0d req 500000", cyc, period);
      end
      n_cmp++;
      if ((cmd_valid && pv) || (cmd_err && pe)) begin
        n_fail++;
        $display("FAIL pulse_width cyc=%0d valid=%b err=%b req 1-cycle",
                 cyc, cmd_valid, cmd_err);
      end
      n_cmp++;
      if (duty_cycle !== prev_duty && !cmd_valid) begin
        n_fail++;
        $display("FAIL duty_glitch cyc=%0d got %0d req %0d",
                 cyc, duty_cycle, prev_duty);
      end
      n_cmp++;
      if (cyc >= m_deadline) begin
        if (duty_cycle !== m_duty) begin
          n_fail++;
          $display("FAIL duty_track cyc=%0d got %0d req %0d",
                   cyc, duty_cycle, m_duty);
        end
      end else if (duty_cycle !== m_duty && duty_cycle !== m_old) begin
        n_fail++;
        $display("FAIL duty_track cyc=%0d got %0d req %0d or %0d",
                 cyc, duty_cycle, m_duty, m_old);
      end
      prev_duty = duty_cycle;
      pv = cmd_valid;
      pe = cmd_err;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d req %0d", nm, act, req);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d req %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic chk_counts(input string nm);
    chk({nm, "_valid_cnt"}, 32'(dut_valid), 32'(m_valid));
    chk({nm, "_err_cnt"}, 32'(dut_err), 32'(m_err));
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    wait_cyc(n);
    if (m_st != M_HUNT && n >= TMO) begin
      m_err++;
      m_st = M_HUNT;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(CPB);
    end
    rx = stop_ok;
    wait_cyc(HALF);
    model_byte(b, stop_ok);
    wait_cyc(CPB - HALF);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    send_byte(c, 1'b1);
    idle(40);
  endtask

  int t_ang;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    m_reset();
    wait_cyc(5);
    chk("rst_duty", duty_cycle, 32'd37_420);
    chk("rst_period", period, 32'd500_000);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    wait_cyc(20);

    send_frame(8'hA5, 8'h00, 8'hFF);
    chk("ang0_duty", duty_cycle, 32'd25_000);
    chk_rng("ang0_lat", last_valid_cyc - m_upd_cyc, 0, 7);
    chk_counts("ang0");

    send_frame(8'hA5, 8'hB4, 8'h4B);
    chk("ang180_duty", duty_cycle, 32'd49_840);
    chk_rng("ang180_lat", last_valid_cyc - m_upd_cyc, 0, 7);
    chk_counts("ang180");

    send_frame(8'hA5, 8'h5A, 8'h00);
    send_frame(8'hA5, 8'hB5, 8'h4A);
    chk("bad_duty", duty_cycle, 32'd49_840);
    chk("bad_err_cnt", 32'(dut_err), 32'd2);
    chk_counts("bad");

    send_byte(8'h33, 1'b1);
    idle(40);
    send_frame(8'hA5, 8'hA5, 8'h5A);
    chk("ang165_duty", duty_cycle, 32'd47_770);
    chk_counts("ang165");

    send_byte(8'hA5, 1'b1);
    send_byte(8'h2D, 1'b1);
    t_ang = m_upd_cyc;
    idle(TMO + 400);
    chk_rng("tmo_time", last_err_cyc - t_ang, TMO - 8, TMO + 8);
    chk("tmo_duty", duty_cycle, 32'd47_770);
    chk_counts("tmo");
    send_byte(8'hD2, 1'b1);
    idle(40);
    chk_counts("tmo_stray");
    send_frame(8'hA5, 8'h2D, 8'hD2);
    chk("ang45_duty", duty_cycle, 32'd31_210);
    chk_counts("ang45");

    rx = 1'b0;
    wait_cyc(3);
    rx = 1'b1;
    wait_cyc(40);
    chk_counts("glitch");

    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b0);
    idle(40);
    send_byte(8'hC3, 1'b1);
    idle(40);
    chk_counts("frame_err");
    send_frame(8'hA5, 8'h3C, 8'hC3);
    chk("ang60_duty", duty_cycle, 32'd33_280);
    chk_counts("ang60");

    send_byte(8'hA5, 1'b1);
    rx = 1'b0;
    wait_cyc(40);
    chk("mid_busy", 32'(rx_busy), 32'd1);
    #3;
    rst = 1'b1;
    m_reset();
    #1;
    chk("arst_duty", duty_cycle, 32'd37_420);
    chk("arst_valid", 32'(cmd_valid), 32'd0);
    chk("arst_err", 32'(cmd_err), 32'd0);
    chk("arst_busy", 32'(rx_busy), 32'd0);
    rx = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(20);
    send_frame(8'hA5, 8'h0A, 8'hF5);
    chk("ang10_duty", duty_cycle, 32'd26_380);
    chk_counts("ang10");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
